// File: rtl/corr_phase_search.sv
// Phase-search sequencer for a 1-bit sig/code correlator: generates the local PN code,
// sweeps it over NPHASE chip offsets with one dwell window each, and keeps the best score.
module corr_phase_search #(
  parameter int unsigned       LFSR_W = 10,
  parameter logic [LFSR_W-1:0] TAPS   = 10'h240,
  parameter logic [LFSR_W-1:0] SEED   = 10'h3FF,
  parameter int unsigned       DWELL  = 1023,
  parameter int unsigned       NPHASE = 1023,
  parameter int unsigned       PH_W   = 10,
  parameter logic signed [32:0] THRESH = 33'sh0_0000_0300
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             result_match,
  input  logic [31:0]             result_miss,
  output logic                    code,
  output logic                    capture,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [PH_W-1:0]         best_phase,
  output logic signed [32:0]      best_metric
);

  localparam int unsigned          CNT_W      = 32;
  localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [PH_W-1:0]      PHASE_LAST = PH_W'(NPHASE - 1);
  localparam logic signed [32:0]   METRIC_MIN = 33'sh1_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DWELL,
    S_CAPTURE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    dwell_cnt;
  logic [PH_W-1:0]     phase;
  logic                eval_pending;

  logic signed [32:0]  metric;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [PH_W-1:0]     score_phase;
  logic                better;
  logic                hit;

  assign code        = lfsr[LFSR_W-1];
  assign metric      = $signed({1'b0, result_match}) - $signed({1'b0, result_miss});
  assign lfsr_next   = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
  // Scoring lags the capture by one cycle; in DWELL the phase counter has already advanced.
  assign score_phase = (state == S_EVAL) ? phase : phase - PH_W'(1);
  assign better      = metric > best_metric;
  assign hit         = metric >= THRESH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      dwell_cnt    <= '0;
      phase        <= '0;
      eval_pending <= 1'b0;
      capture      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      best_phase   <= '0;
      best_metric  <= METRIC_MIN;
    end else if (state == S_IDLE) begin
      capture <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        state        <= S_FLUSH;
        lfsr         <= SEED;
        phase        <= '0;
        eval_pending <= 1'b0;
        found        <= 1'b0;
        best_metric  <= METRIC_MIN;
        best_phase   <= '0;
        capture      <= 1'b1;
        busy         <= 1'b1;
      end
    end else if (abort) begin
      // Abort wins over any pending score or early exit; partial results are kept.
      state        <= S_IDLE;
      eval_pending <= 1'b0;
      capture      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_FLUSH: begin
          state     <= S_DWELL;
          dwell_cnt <= '0;
          capture   <= 1'b0;
        end
        S_DWELL: begin
          lfsr      <= lfsr_next;
          dwell_cnt <= dwell_cnt + CNT_W'(1);
          if (dwell_cnt == DWELL_LAST) begin
            state   <= S_CAPTURE;
            capture <= 1'b1;
          end
          if (eval_pending) begin
            eval_pending <= 1'b0;
            if (better) begin
              best_metric <= metric;
              best_phase  <= score_phase;
            end
            if (hit) begin
              found   <= 1'b1;
              state   <= S_DONE;
              done    <= 1'b1;
              capture <= 1'b0;
            end
          end
        end
        S_CAPTURE: begin
          // LFSR holds here: the one-chip slip that moves each window by one offset.
          capture      <= 1'b0;
          eval_pending <= 1'b1;
          if (phase == PHASE_LAST) begin
            state <= S_EVAL;
          end else begin
            state     <= S_DWELL;
            phase     <= phase + PH_W'(1);
            dwell_cnt <= '0;
          end
        end
        S_EVAL: begin
          eval_pending <= 1'b0;
          if (better) begin
            best_metric <= metric;
            best_phase  <= score_phase;
          end
          if (hit) begin
            found <= 1'b1;
          end
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          capture <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
